// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin grant arbiter that hands each granted requester a
// word from an external Galois LFSR and services LFSR reseed requests.
// Optional feature macro: RNG_ARBITER_STAT_EN adds per-requester 16-bit
// saturating grant counters on gnt_cnt_o.
module rng_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned VAL_WIDTH = 32,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    seed_wr_i,
  input  logic [VAL_WIDTH-1:0]    seed_i,
  output logic                    lfsr_wr_o,
  output logic [VAL_WIDTH-1:0]    lfsr_dat_o,
  input  logic [VAL_WIDTH-1:0]    lfsr_val_i,
  input  logic [NUM_REQ-1:0]      req_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [VAL_WIDTH-1:0]    dat_o,
`ifdef RNG_ARBITER_STAT_EN
  output logic [NUM_REQ*16-1:0]   gnt_cnt_o,
`endif
  output logic                    seed_pend_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GAP_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    GRANT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [VAL_WIDTH-1:0] seed_q, seed_d;
  logic                 pend_d;
  logic [NUM_REQ-1:0]   gnt_d;
  logic [VAL_WIDTH-1:0] dat_d;
  logic                 lfsr_wr_d;
  logic [VAL_WIDTH-1:0] lfsr_dat_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  int unsigned          rr_idx;

  // Round-robin search: first active request at or after ptr_q, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!win_found && req_i[IDX_W'(rr_idx)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(rr_idx);
      end
    end
  end

  // Next-state and next-output logic; seed capture overrides the SEED clear
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    gap_d      = gap_q;
    seed_d     = seed_q;
    pend_d     = seed_pend_o;
    gnt_d      = '0;
    dat_d      = '0;
    lfsr_wr_d  = 1'b0;
    lfsr_dat_d = '0;

    case (state_q)
      IDLE: begin
        if (seed_pend_o) begin
          state_d    = SEED;
          lfsr_wr_d  = 1'b1;
          lfsr_dat_d = seed_q;
          pend_d     = 1'b0;
        end else if (!seed_wr_i && en_i && win_found) begin
          // An arriving seed write holds off the grant so the seed goes first
          state_d = GRANT;
          gnt_d   = NUM_REQ'(1) << win_idx;
          dat_d   = lfsr_val_i;
          win_d   = win_idx;
        end
      end
      GRANT: begin
        ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
        state_d = GAP;
        gap_d   = GAP_W'(GAP_CYC - 1);
      end
      SEED: begin
        state_d = GAP;
        gap_d   = GAP_W'(GAP_CYC - 1);
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (seed_wr_i) begin
      seed_d = (seed_i == '0) ? VAL_WIDTH'(1) : seed_i;
      pend_d = 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      gap_q       <= '0;
      seed_q      <= '0;
      seed_pend_o <= 1'b0;
      gnt_o       <= '0;
      dat_o       <= '0;
      lfsr_wr_o   <= 1'b0;
      lfsr_dat_o  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      gap_q       <= gap_d;
      seed_q      <= seed_d;
      seed_pend_o <= pend_d;
      gnt_o       <= gnt_d;
      dat_o       <= dat_d;
      lfsr_wr_o   <= lfsr_wr_d;
      lfsr_dat_o  <= lfsr_dat_d;
    end
  end

`ifdef RNG_ARBITER_STAT_EN
  // Per-requester saturating grant counters, bumped in the GRANT cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_cnt_o <= '0;
    end else if (state_q == GRANT) begin
      if (gnt_cnt_o[32'(win_q)*16 +: 16] != 16'hFFFF) begin
        gnt_cnt_o[32'(win_q)*16 +: 16] <= gnt_cnt_o[32'(win_q)*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/rng_arbiter.md
RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 SHALL have parameter VAL_WIDTH, default 32: random word width, matching the Galois LFSR width.
REQ-003 SHALL have parameter GAP_CYC, default 2: idle cycles after each grant, legal range 1..15.
REQ-004 SHALL provide clk_i  input  1  single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL provide rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL provide en_i  input  1  grant enable; when low, no new grants are issued.
REQ-007 SHALL provide seed_wr_i  input  1  one-cycle pulse requesting an LFSR reseed.
REQ-008 SHALL provide seed_i  input  VAL_WIDTH  seed value, sampled when seed_wr_i is high.
REQ-009 SHALL provide lfsr_wr_o  output  1  LFSR load strobe, driving the LFSR wr_i.
REQ-010 SHALL provide lfsr_dat_o  output  VAL_WIDTH  LFSR load value, driving the LFSR dat_i.
REQ-011 SHALL provide lfsr_val_i  input  VAL_WIDTH  current LFSR output.
REQ-012 SHALL provide req_i  input  NUM_REQ  per-requester level request; each bit is held until granted.
REQ-013 SHALL provide gnt_o  output  NUM_REQ  one-hot grant, high for exactly 1 cycle.
REQ-014 SHALL provide dat_o  output  VAL_WIDTH  random word for the granted requester; 0 when gnt_o==0.
REQ-015 SHALL provide seed_pend_o  output  1  high while a seed is captured but not yet written to the LFSR.

Function
REQ-016 SHALL implement FSM states IDLE, SEED, GRANT, GAP; all outputs registered.
REQ-017 SHALL, in IDLE with a seed pending, go to SEED; a pending seed has priority over requests.
REQ-018 SHALL, in IDLE with no seed pending, en_i=1 and |req_i, pick the round-robin winner starting at pointer ptr, register gnt_o and dat_o=lfsr_val_i, and go to GRANT.
REQ-019 SHALL hold gnt_o and dat_o valid for the single GRANT cycle, set ptr=(winner+1) mod NUM_REQ, then go to GAP.
REQ-020 SHALL remain in GAP for exactly GAP_CYC cycles, then go to IDLE; minimum spacing between grants is GAP_CYC+2 cycles.
REQ-021 SHALL, in SEED, assert lfsr_wr_o for exactly 1 cycle with lfsr_dat_o set to the pending seed, clear seed_pend_o, then go to GAP.
REQ-022 SHALL substitute 1 for a captured seed of 0, preventing LFSR lock-up.
REQ-023 SHALL capture seed_wr_i in any state; when several writes occur before service, the last value wins; seed_pend_o rises the cycle after capture.
REQ-024 SHALL, when seed_wr_i coincides with the SEED cycle, keep the new seed pending for the next service.
REQ-025 SHALL NOT grant a requester whose req_i fell before the IDLE decision cycle; requests are sampled only in IDLE.
REQ-026 SHALL, when en_i falls during GRANT or GAP, complete that sequence and then issue no further grants; seeds are still serviced.
REQ-027 SHALL drive lfsr_dat_o=0 whenever lfsr_wr_o=0.

Reset
REQ-028 SHALL, on rst_i=1 at a clock edge, set state=IDLE, ptr=0, gnt_o=0, dat_o=0, lfsr_wr_o=0, lfsr_dat_o=0, seed_pend_o=0, and clear the pending seed.
REQ-029 SHALL, on reset asserted mid-GRANT or mid-SEED, drop gnt_o and lfsr_wr_o on the next edge and discard the sequence.

Configuration
REQ-030 SHALL, with macro RNG_ARBITER_STAT_EN defined, add output gnt_cnt_o of width NUM_REQ*16: one 16-bit saturating grant counter per requester, cleared by reset and incremented in the GRANT cycle.
REQ-031 SHALL, without RNG_ARBITER_STAT_EN, have no gnt_cnt_o port and no counter logic; all other behaviour is identical.

Verification
REQ-032 SHALL cover: GAP_CYC=2, req_i=4'b1111 held, lfsr_val_i=32'hA5A5_0001 -> grants 0,1,2,3,0 every 4 cycles, with dat_o equal to lfsr_val_i sampled in each IDLE decision cycle.
REQ-033 SHALL cover: seed_wr_i with seed_i=32'h0 in IDLE -> seed_pend_o=1, then lfsr_wr_o=1 with lfsr_dat_o=32'h1 for 1 cycle, then 2 GAP cycles.
REQ-034 SHALL cover: seed_wr_i and req_i=4'b0100 in the same IDLE cycle -> SEED first, then gnt_o=4'b0100 after GAP.
REQ-035 SHALL cover: seeds 32'h11 then 32'h22 during GAP -> single lfsr_wr_o with 32'h22.
REQ-036 SHALL cover: en_i=0 with req_i=4'b0011 -> gnt_o stays 0; en_i=1 -> gnt_o=4'b0001.
REQ-037 SHALL cover: with RNG_ARBITER_STAT_EN, 70000 grants to requester 0 -> gnt_cnt_o[15:0]=16'hFFFF; rst_i pulse -> 0.
